// File: rtl/rsa_host_sequencer.sv
// rsa_host_sequencer: hardware initiator for the ARM<->FPGA RSA command/data
// protocol. It runs one job as load operands -> compute -> fetch result, using
// the same cmd/data/done handshake that ARM software normally drives. Every
// output is registered, so all strobes are glitch-free one-cycle pulses.
module rsa_host_sequencer #(
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int TW             = 17
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [4:0]    load_mask,
  input  logic [1023:0] in_x,
  input  logic [1023:0] in_e,
  input  logic [1023:0] in_r,
  input  logic [1023:0] in_r2,
  input  logic [1023:0] in_m,
  input  logic [9:0]    in_t,
  output logic          busy,
  output logic          job_done,
  output logic          error,
  output logic [1023:0] result,
  output logic [31:0]   arm_to_fpga_cmd,
  output logic          arm_to_fpga_cmd_valid,
  input  logic          arm_to_fpga_done,
  output logic          arm_to_fpga_done_read,
  output logic          arm_to_fpga_data_valid,
  input  logic          arm_to_fpga_data_ready,
  output logic [1023:0] arm_to_fpga_data,
  input  logic          fpga_to_arm_data_valid,
  output logic          fpga_to_arm_data_ready,
  input  logic [1023:0] fpga_to_arm_data
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_DREADY,
    S_WAIT_RVALID,
    S_WAIT_DONE,
    S_WAIT_DONE_LOW,
    S_FINISH
  } state_t;

  // Op indices 0..4 are the operand loads X, E, R, R2, M.
  localparam logic [2:0] OP_COMPUTE = 3'd5;
  localparam logic [2:0] OP_RESULT  = 3'd6;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  state_t        state, state_next;
  logic [2:0]    op_idx, op_next;
  logic [TW-1:0] tmo_cnt;
  logic          tmo_expired;
  logic          in_wait;

  logic          fire_data;
  logic          fire_result;
  logic          fire_ack;
  logic          hit_timeout;
  logic          accept;

  logic [4:0]    mask_q;
  logic [9:0]    t_q;
  logic [9:0]    t_sel;
  logic [1023:0] x_q, e_q, r_q, r2_q, m_q;
  logic [1023:0] operand_sel;

  // Lowest op index >= from that must run: unmasked loads, compute, result.
  function automatic logic [2:0] first_op(input logic [2:0] from, input logic [4:0] mask);
    logic [2:0] idx;
    idx = (from > OP_COMPUTE) ? from : OP_COMPUTE;
    for (int i = 4; i >= 0; i--) begin
      if (3'(i) >= from && mask[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  // Command word for an op: loads are odd codes 1..9, compute carries t.
  function automatic logic [31:0] cmd_word(input logic [2:0] idx, input logic [9:0] t);
    if (idx == OP_COMPUTE)     return {t, 22'd0};
    else if (idx == OP_RESULT) return 32'd2;
    else                       return {28'd0, idx, 1'b1};
  endfunction

  assign accept      = (state == S_IDLE) && start;
  assign tmo_expired = (tmo_cnt == TMO_LAST);
  assign in_wait     = (state == S_WAIT_DREADY) || (state == S_WAIT_RVALID) ||
                       (state == S_WAIT_DONE)   || (state == S_WAIT_DONE_LOW);
  // The first op is issued in the same cycle that t is latched.
  assign t_sel       = (state == S_IDLE) ? in_t : t_q;

  // Operand driven for the current load op.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    operand_sel = m_q;
    case (op_idx)
      3'd0:    operand_sel = x_q;
      3'd1:    operand_sel = e_q;
      3'd2:    operand_sel = r_q;
      3'd3:    operand_sel = r2_q;
      default: operand_sel = m_q;
    endcase
  end

  // Next-state logic and handshake events; a handshake wins over a timeout in the same cycle.
  always_comb begin
    state_next  = state;
    op_next     = op_idx;
    fire_data   = 1'b0;
    fire_result = 1'b0;
    fire_ack    = 1'b0;
    hit_timeout = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_next = S_ISSUE;
          op_next    = first_op(3'd0, load_mask);
        end
      end
      S_ISSUE: begin
        if (op_idx == OP_COMPUTE)     state_next = S_WAIT_DONE;
        else if (op_idx == OP_RESULT) state_next = S_WAIT_RVALID;
        else                          state_next = S_WAIT_DREADY;
      end
      S_WAIT_DREADY: begin
        if (arm_to_fpga_data_ready) begin
          fire_data  = 1'b1;
          state_next = S_WAIT_DONE;
        end else if (tmo_expired) begin
          hit_timeout = 1'b1;
          state_next  = S_FINISH;
        end
      end
      S_WAIT_RVALID: begin
        if (fpga_to_arm_data_valid) begin
          fire_result = 1'b1;
          state_next  = S_WAIT_DONE;
        end else if (tmo_expired) begin
          hit_timeout = 1'b1;
          state_next  = S_FINISH;
        end
      end
      S_WAIT_DONE: begin
        if (arm_to_fpga_done) begin
          fire_ack   = 1'b1;
          state_next = S_WAIT_DONE_LOW;
        end else if (tmo_expired) begin
          hit_timeout = 1'b1;
          state_next  = S_FINISH;
        end
      end
      S_WAIT_DONE_LOW: begin
        // The responder's done is registered; wait for it to drop so it is not taken twice.
        if (!arm_to_fpga_done) begin
          if (op_idx == OP_RESULT) begin
            state_next = S_FINISH;
          end else begin
            state_next = S_ISSUE;
            op_next    = first_op(op_idx + 3'd1, mask_q);
          end
        end else if (tmo_expired) begin
          hit_timeout = 1'b1;
          state_next  = S_FINISH;
        end
      end
      S_FINISH: state_next = S_IDLE;
      default:  state_next = S_IDLE;
    endcase
  end

  // State and op-index registers.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state  <= S_IDLE;
      op_idx <= 3'd0;
    end else begin
      state  <= state_next;
      op_idx <= op_next;
    end
  end

  // Wait-state timeout counter, cleared on every state change.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    tmo_cnt <= '0;
    else if (state_next != state) tmo_cnt <= '0;
    else if (in_wait)             tmo_cnt <= tmo_cnt + TW'(1);
  end

  // Job parameters captured when a job is accepted; ignored while busy.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: the wide operand registers are reset on purpose so a fresh job never sees stale operands.
    if (reset) begin
      mask_q <= '0;
      t_q    <= '0;
      x_q    <= '0;
      e_q    <= '0;
      r_q    <= '0;
      r2_q   <= '0;
      m_q    <= '0;
    end else if (accept) begin
      mask_q <= load_mask;
      t_q    <= in_t;
      x_q    <= in_x;
      e_q    <= in_e;
      r_q    <= in_r;
      r2_q   <= in_r2;
      m_q    <= in_m;
    end
  end

  // Registered bus outputs, strobes and job status.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy                   <= 1'b0;
      job_done               <= 1'b0;
      error                  <= 1'b0;
      result                 <= '0;
      arm_to_fpga_cmd        <= '0;
      arm_to_fpga_cmd_valid  <= 1'b0;
      arm_to_fpga_done_read  <= 1'b0;
      arm_to_fpga_data_valid <= 1'b0;
      arm_to_fpga_data       <= '0;
      fpga_to_arm_data_ready <= 1'b0;
    end else begin
      busy                   <= (state_next != S_IDLE) && (state_next != S_FINISH);
      job_done               <= (state_next == S_FINISH);
      arm_to_fpga_cmd_valid  <= (state_next == S_ISSUE);
      arm_to_fpga_data_valid <= fire_data;
      fpga_to_arm_data_ready <= fire_result;
      arm_to_fpga_done_read  <= fire_ack;

      if (accept)           error <= 1'b0;
      else if (hit_timeout) error <= 1'b1;

      // The command stays stable from ISSUE until the op completes; zero between jobs.
      if (state_next == S_ISSUE)
        arm_to_fpga_cmd <= cmd_word(op_next, t_sel);
      else if (state_next == S_FINISH || state_next == S_IDLE)
        arm_to_fpga_cmd <= '0;

      if (fire_data)   arm_to_fpga_data <= operand_sel;
      if (fire_result) result           <= fpga_to_arm_data;
    end
  end

endmodule

// File: doc/rsa_host_sequencer.md
Name: rsa_host_sequencer

Overview:
Hardware initiator for the ARM<->FPGA command/data protocol. It drives the same handshake the ARM software normally drives, so an RSA job can be issued without the processor, and the block doubles as a synthesizable bus-functional master for bench and board bring-up. A job runs in order: load operands, issue compute, fetch result, return result to the local requester.

Parameters:
TIMEOUT_CYCLES, 65536, max cycles spent in any single wait state before the job aborts with error
TW, 17, timeout counter width; must satisfy 2^TW > TIMEOUT_CYCLES

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle job request; ignored while busy=1
load_mask  in  5  bit0 X, bit1 E, bit2 R, bit3 R2, bit4 M; a 0 bit skips reloading that operand
in_x, in_e, in_r, in_r2, in_m  in  1024 each  operands
in_t  in  10  exponent bit length, placed in cmd[31:22]
busy  out  1  job in progress
job_done  out  1  one-cycle pulse at job end (success or error)
error  out  1  sticky; cleared on the next accepted start
result  out  1024  captured result; holds its value until the next successful capture
arm_to_fpga_cmd  out  32  command word; held stable for the whole transaction
arm_to_fpga_cmd_valid  out  1  one-cycle command strobe
arm_to_fpga_done  in  1  responder done
arm_to_fpga_done_read  out  1  one-cycle done acknowledge
arm_to_fpga_data_valid  out  1  one-cycle operand strobe
arm_to_fpga_data_ready  in  1  responder ready for operand
arm_to_fpga_data  out  1024  operand word
fpga_to_arm_data_valid  in  1  result valid
fpga_to_arm_data_ready  out  1  one-cycle result acknowledge
fpga_to_arm_data  in  1024  result word

Behaviour:
- Reset: all outputs 0; state IDLE; op index 0; latched operands 0.
- On start in IDLE: latch operands, mask and t; clear error; set busy=1.
- Op sequence, index 0..6: X(cmd 1), E(3), R(5), R2(7), M(9), COMPUTE(cmd = {t,22'd0}), RESULT(cmd 2). Load ops whose mask bit is 0 are skipped, with no bus activity.
- States:
  - IDLE
  - ISSUE: drive cmd; pulse cmd_valid for one cycle.
    - Load op -> WAIT_DREADY.
    - COMPUTE -> WAIT_DONE.
    - RESULT -> WAIT_RVALID.
  - WAIT_DREADY: on data_ready=1, drive data and pulse data_valid for one cycle -> WAIT_DONE.
  - WAIT_RVALID: on fpga_to_arm_data_valid=1, capture fpga_to_arm_data into result and pulse fpga_to_arm_data_ready for one cycle -> WAIT_DONE.
  - WAIT_DONE: on done=1, pulse done_read for one cycle -> WAIT_DONE_LOW.
  - WAIT_DONE_LOW: wait for done=0, so the responder's registered done is not re-consumed. Then increment index: if index was 6 -> FINISH, else -> ISSUE.
  - FINISH: pulse job_done; busy=0 -> IDLE.
- arm_to_fpga_cmd holds its value from ISSUE until the op leaves WAIT_DONE_LOW. It is 0 in IDLE.
- Responder handshake outputs are registered and lag by one cycle. The block samples data_ready and fpga_to_arm_data_valid only in their own wait state; a stale high level in any other state is ignored.
- Timeout: a counter resets on each state entry and counts in every WAIT_* state. When it reaches TIMEOUT_CYCLES: error=1, result unchanged, no further strobes -> FINISH.
- start while busy: ignored, with no effect on latched operands.
- Reset mid-job: immediate abort to reset values; no strobes in the cycle after reset deasserts.
- All strobes are exactly one cycle wide and mutually exclusive.

Test Plan:
- Full job against an rsa_wrapper instance: x=5, e=3, m=33, r/r2 as precomputed, t=2, mask=5'b11111 -> cmd sequence 1,3,5,7,9,{2,22'd0},2; result=26 (5^3 mod 33); job_done one pulse; error=0.
- mask=5'b00001 -> bus sees only cmds 1, compute, 2; E/R/R2/M values retained from the previous job in the responder; result correct.
- Responder model holds done high 3 extra cycles after done_read -> sequencer waits in WAIT_DONE_LOW and issues exactly one next cmd_valid; no double ack.
- Responder never asserts data_ready, TIMEOUT_CYCLES=16 -> error=1 and job_done 16 cycles after entering WAIT_DREADY; busy=0; result unchanged.
- start pulsed during a busy job with different in_x -> ignored; the first job's result is unaffected.
- reset asserted during WAIT_RVALID -> all outputs 0 asynchronously; a new start afterwards completes a normal job.
